irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL provide parameter NUM_SRC, default 8, meaning number of interrupt sources (legal range 1..31).
REQ-002 SHALL provide parameter VEC_W, default 4, meaning vector width; 2**VEC_W > NUM_SRC SHALL be checked at elaboration.
REQ-003 SHALL provide parameter EDGE_MASK, default all ones, meaning per-source mode (1 = rising-edge, 0 = level).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 irq_src  input  NUM_SRC  interrupt requests, synchronous to clk.
REQ-007 interrupt_vector  output  VEC_W  0 = none; source i presents i+1.
REQ-008 interrupt_ack  input  1  CPU acknowledges the presented vector.
REQ-009 irq_any  output  1  OR of enabled pending bits.
REQ-010 reg_sel, reg_we, reg_re  input  1 each  register-port select, write strobe, read strobe.
REQ-011 reg_addr  input  2  register word index.
REQ-012 reg_wdata  input  32  write data; reg_rdata  output  32  registered read data.

Function
REQ-013 Registers SHALL be: 0 ENABLE (RW), 1 PENDING (read; write-1-to-clear), 2 CURRENT (read presented vector), 3 SWTRIG (write-1-to-set pending); all NUM_SRC bits wide, zero-extended to 32.
REQ-014 Edge source SHALL set its pending bit on the clock where irq_src=1 and its previous-cycle sample was 0; level source SHALL set pending on every clock it is 1.
REQ-015 Pending bits SHALL latch regardless of ENABLE; only enabled pending bits compete for presentation.
REQ-016 Priority SHALL be fixed: lowest source index wins.
REQ-017 FSM SHALL have states IDLE, PRESENT, GAP.
REQ-018 IDLE: vector 0; if any enabled pending bit exists, go to PRESENT on the next edge with interrupt_vector = winner+1.
REQ-019 Latency: edge source rising sampled at edge T sets pending at T; vector valid after edge T+1.
REQ-020 PRESENT: vector SHALL stay constant until interrupt_ack=1, even if ENABLE or PENDING change; on ack clear that source's pending bit and go to GAP.
REQ-021 GAP: vector 0 for exactly one cycle, ack ignored, then IDLE.
REQ-022 interrupt_ack in IDLE or GAP SHALL be ignored; ack held high SHALL cause exactly one acknowledge.
REQ-023 Set and clear of the same pending bit in one cycle (edge/level/SWTRIG vs ack/W1C) SHALL resolve to set.
REQ-024 A register write SHALL take effect on the clock where reg_sel&reg_we=1; ignored when reg_sel=0.
REQ-025 reg_rdata SHALL update one clock after reg_sel&reg_re=1 and hold its value otherwise.
REQ-026 Writes to bits >= NUM_SRC SHALL be ignored; reads of them return 0.

Reset
REQ-027 While reset=1: FSM=IDLE, interrupt_vector=0, irq_any=0, reg_rdata=0, ENABLE=0, PENDING=0, edge history=0.
REQ-028 Reset mid-PRESENT SHALL drop the vector to 0 immediately (asynchronously); no interrupt survives reset.
REQ-029 After reset release, a source already high SHALL count as a rising edge on the first clock.

Structure
REQ-030 Shared package irq_pkg SHALL hold register offsets (ENABLE, PENDING, CURRENT, SWTRIG) and FSM state encoding.
REQ-031 One sub-module irq_prio_enc (NUM_SRC-in, lowest-index winner plus valid flag, combinational) SHALL be instantiated.

Verification
REQ-032 ENABLE=0x01, pulse irq_src[0] one cycle -> vector 1 after second edge; ack -> PENDING=0, vector 0 for one GAP cycle.
REQ-033 ENABLE=0xFF, irq_src[5] and [2] rise together -> vector 3, after ack+GAP vector 6.
REQ-034 Vector 6 presented, then irq_src[0] rises -> vector stays 6 until ack, next presentation is 1.
REQ-035 Level source 3 (EDGE_MASK bit 3=0) held high, ack -> after GAP vector 4 presented again.
REQ-036 ENABLE=0, SWTRIG write 0x10 -> PENDING reads 0x10 next cycle, vector 0; write ENABLE=0x10 -> vector 5; write PENDING 0x10 same cycle as a new edge on source 4 -> bit stays set.
REQ-037 Assert reset while vector=5 -> vector 0 without a clock edge; all registers read 0 after release.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register word offsets
// and the presentation FSM state encoding.
package irq_pkg;

   localparam logic [1:0] REG_ENABLE  = 2'd0;
   localparam logic [1:0] REG_PENDING = 2'd1;
   localparam logic [1:0] REG_CURRENT = 2'd2;
   localparam logic [1:0] REG_SWTRIG  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_GAP     = 2'd2
   } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins, plus a valid flag.
module irq_prio_enc #(
   parameter int N = 8,
   parameter int W = 4
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid
);

   // Scan high to low so the last assignment is the lowest set index.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = W'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge/level capture into PENDING, fixed-priority
// vector presentation with an IDLE/PRESENT/GAP handshake, 4-word register port.
module irq_controller #(
   parameter int                 NUM_SRC   = 8,
   parameter int                 VEC_W     = 4,
   parameter logic [NUM_SRC-1:0] EDGE_MASK = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic [VEC_W-1:0]   interrupt_vector,
   input  logic               interrupt_ack,
   output logic               irq_any,
   input  logic               reg_sel,
   input  logic               reg_we,
   input  logic               reg_re,
   input  logic [1:0]         reg_addr,
   input  logic [31:0]        reg_wdata,
   output logic [31:0]        reg_rdata
);
   import irq_pkg::*;

   if (NUM_SRC < 1 || NUM_SRC > 31) begin : g_chk_num_src
      $error("irq_controller: NUM_SRC must be in 1..31");
   end
   if ((2 ** VEC_W) <= NUM_SRC) begin : g_chk_vec_w
      $error("irq_controller: VEC_W too narrow for NUM_SRC+1 vectors");
   end

   logic [NUM_SRC-1:0] r_en, r_pend, r_prev;
   logic [31:0]        r_rdata;
   logic               r_ack_q;
   irq_state_t         r_state;
   logic [VEC_W-1:0]   r_vec, r_cur;

   logic [NUM_SRC-1:0] w_req, w_set, w_clr;
   logic [VEC_W-1:0]   w_win;
   logic               w_valid, w_wr, w_rd, w_ack;
   logic               w_unused;

   assign w_wr     = reg_sel & reg_we;
   assign w_rd     = reg_sel & reg_re;
   assign w_req    = r_en & r_pend;
   assign w_unused = &{1'b0, reg_wdata[31:NUM_SRC]};
   // Ack is edge-detected so a held ack retires only one presentation.
   assign w_ack    = interrupt_ack & ~r_ack_q & (r_state == ST_PRESENT);

   irq_prio_enc #(.N(NUM_SRC), .W(VEC_W)) u_prio (
      .req   (w_req),
      .idx   (w_win),
      .valid (w_valid)
   );

   always_comb begin
      w_set = (irq_src & ~r_prev & EDGE_MASK) | (irq_src & ~EDGE_MASK);
      w_clr = '0;
      if (w_wr && reg_addr == REG_SWTRIG)  w_set = w_set | reg_wdata[NUM_SRC-1:0];
      if (w_wr && reg_addr == REG_PENDING) w_clr = reg_wdata[NUM_SRC-1:0];
      if (w_ack)                           w_clr = w_clr | (NUM_SRC'(1) << r_cur);
   end

   // Set terms are OR-ed in after clears so a same-cycle set always wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_en    <= '0;
         r_pend  <= '0;
         r_prev  <= '0;
         r_ack_q <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_prev  <= irq_src;
         r_ack_q <= interrupt_ack;
         r_pend  <= (r_pend & ~w_clr) | w_set;
         if (w_wr && reg_addr == REG_ENABLE) r_en <= reg_wdata[NUM_SRC-1:0];
         if (w_rd) begin
            case (reg_addr)
               REG_ENABLE:  r_rdata <= 32'(r_en);
               REG_PENDING: r_rdata <= 32'(r_pend);
               REG_CURRENT: r_rdata <= 32'(r_vec);
               default:     r_rdata <= '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_cur   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_valid) begin
               r_state <= ST_PRESENT;
               r_cur   <= w_win;
               r_vec   <= w_win + VEC_W'(1);
            end
            ST_PRESENT: if (w_ack) begin
               r_state <= ST_GAP;
               r_vec   <= '0;
            end
            ST_GAP:  r_state <= ST_IDLE;
            default: begin
               r_state <= ST_IDLE;
               r_vec   <= '0;
            end
         endcase
      end
   end

   assign interrupt_vector = r_vec;
   assign irq_any          = |w_req;
   assign reg_rdata        = r_rdata;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: source 3 is level, all others edge.
module tb_irq_controller;
   import irq_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  irq_src = '0;
   logic [3:0]  interrupt_vector;
   logic        interrupt_ack = 1'b0;
   logic        irq_any;
   logic        reg_sel = 1'b0, reg_we = 1'b0, reg_re = 1'b0;
   logic [1:0]  reg_addr = '0;
   logic [31:0] reg_wdata = '0;
   logic [31:0] reg_rdata;

   int n_chk = 0;
   int n_err = 0;

   irq_controller #(.NUM_SRC(8), .VEC_W(4), .EDGE_MASK(8'hF7)) dut (
      .clk              (clk),
      .reset            (reset),
      .irq_src          (irq_src),
      .interrupt_vector (interrupt_vector),
      .interrupt_ack    (interrupt_ack),
      .irq_any          (irq_any),
      .reg_sel          (reg_sel),
      .reg_we           (reg_we),
      .reg_re           (reg_re),
      .reg_addr         (reg_addr),
      .reg_wdata        (reg_wdata),
      .reg_rdata        (reg_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      tick;
      reg_sel = 1'b0; reg_we = 1'b0;
   endtask

   task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      reg_sel = 1'b1; reg_re = 1'b1; reg_addr = a;
      tick;
      reg_sel = 1'b0; reg_re = 1'b0;
      chk(tag, reg_rdata, exp);
   endtask

   task automatic ack_pulse;
      interrupt_ack = 1'b1;
      tick;
      interrupt_ack = 1'b0;
   endtask

   initial begin
      tick; tick;
      chk("rst_vec", 32'(interrupt_vector), 0);
      chk("rst_any", 32'(irq_any), 0);
      chk("rst_rdata", reg_rdata, 0);
      reset = 1'b0;

      // single edge source, full handshake
      wr(REG_ENABLE, 32'h01);
      irq_src = 8'h01; tick;
      chk("t1_not_yet", 32'(interrupt_vector), 0);
      irq_src = 8'h00; tick;
      chk("t1_vec", 32'(interrupt_vector), 1);
      chk("t1_any", 32'(irq_any), 1);
      ack_pulse;
      chk("t1_gap", 32'(interrupt_vector), 0);
      rdchk("t1_pend_clr", REG_PENDING, 0);
      chk("t1_idle", 32'(interrupt_vector), 0);

      // two sources together, then ack held high
      wr(REG_ENABLE, 32'hFF);
      irq_src = 8'h24; tick;
      irq_src = 8'h00; tick;
      chk("t2_vec3", 32'(interrupt_vector), 3);
      interrupt_ack = 1'b1; tick;
      chk("t2_gap", 32'(interrupt_vector), 0);
      tick;
      chk("t2_idle", 32'(interrupt_vector), 0);
      tick;
      chk("t2_vec6", 32'(interrupt_vector), 6);
      tick;
      chk("t2_ack_held", 32'(interrupt_vector), 6);
      interrupt_ack = 1'b0;

      // higher priority arrives during presentation
      irq_src = 8'h01; tick;
      irq_src = 8'h00; tick;
      chk("t3_hold6", 32'(interrupt_vector), 6);
      chk("t3_any", 32'(irq_any), 1);
      ack_pulse; tick; tick;
      chk("t3_vec1", 32'(interrupt_vector), 1);
      ack_pulse; tick; tick;
      chk("t3_done", 32'(interrupt_vector), 0);
      rdchk("t3_pend", REG_PENDING, 0);

      // level source 3 re-presents after ack
      irq_src = 8'h08; tick; tick;
      chk("t4_vec4", 32'(interrupt_vector), 4);
      ack_pulse;
      chk("t4_gap", 32'(interrupt_vector), 0);
      tick; tick;
      chk("t4_again", 32'(interrupt_vector), 4);
      irq_src = 8'h00;
      ack_pulse; tick; tick;
      chk("t4_done", 32'(interrupt_vector), 0);
      rdchk("t4_pend", REG_PENDING, 0);

      // software trigger, enable masking, register port corners
      wr(REG_ENABLE, 32'h00);
      wr(REG_SWTRIG, 32'h10);
      rdchk("t5_pend_sw", REG_PENDING, 32'h10);
      chk("t5_masked_vec", 32'(interrupt_vector), 0);
      chk("t5_masked_any", 32'(irq_any), 0);
      wr(REG_ENABLE, 32'hABCD_0010);
      rdchk("t5_en_upper", REG_ENABLE, 32'h10);
      chk("t5_vec5", 32'(interrupt_vector), 5);
      rdchk("t5_current", REG_CURRENT, 5);
      reg_sel = 1'b0; reg_we = 1'b1; reg_addr = REG_ENABLE; reg_wdata = 32'hFF;
      tick;
      reg_we = 1'b0;
      rdchk("t5_nosel", REG_ENABLE, 32'h10);
      reg_sel = 1'b1; reg_we = 1'b1; reg_addr = REG_PENDING; reg_wdata = 32'h10;
      irq_src = 8'h10;
      tick;
      reg_sel = 1'b0; reg_we = 1'b0; irq_src = 8'h00;
      rdchk("t5_set_wins", REG_PENDING, 32'h10);
      tick;
      chk("t5_rdata_hold", reg_rdata, 32'h10);
      wr(REG_PENDING, 32'h10);
      rdchk("t5_w1c", REG_PENDING, 0);
      chk("t5_vec_stable", 32'(interrupt_vector), 5);

      // async reset mid-presentation, source already high at release
      #3;
      reset = 1'b1; irq_src = 8'h02;
      #1;
      chk("t6_async_vec", 32'(interrupt_vector), 0);
      chk("t6_async_any", 32'(irq_any), 0);
      chk("t6_async_rdata", reg_rdata, 0);
      tick;
      reset = 1'b0;
      rdchk("t6_en", REG_ENABLE, 0);
      rdchk("t6_cur", REG_CURRENT, 0);
      rdchk("t6_first_edge", REG_PENDING, 32'h02);
      chk("t6_vec", 32'(interrupt_vector), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
